// File: rtl/multi_chan_gnt_arb_if.sv
// multi_chan_gnt_arb_if
// Bundle between NCH requesting agents and the grant arbiter.
//   ack       : per-channel request, bit i = channel i wants the resource
//   irq       : flattened irq vectors, channel i at [i*IRQ_W +: IRQ_W]
//   gnt       : one-hot grant
//   gnt_valid : OR of gnt
//   gnt_id    : index of the granted channel
//   irq_out   : irq vector of the winner, captured at grant
//   timeout   : one-cycle pulse when a grant is revoked for exceeding its hold limit
// master = agent side (drives ack/irq), slave = arbiter side.
interface multi_chan_gnt_arb_if #(
  parameter int NCH   = 4,
  parameter int IRQ_W = 8
);
  localparam int IDW = $clog2(NCH);

  logic [NCH-1:0]       ack;
  logic [NCH*IRQ_W-1:0] irq;
  logic [NCH-1:0]       gnt;
  logic                 gnt_valid;
  logic [IDW-1:0]       gnt_id;
  logic [IRQ_W-1:0]     irq_out;
  logic                 timeout;

  modport master (
    output ack, irq,
    input  gnt, gnt_valid, gnt_id, irq_out, timeout
  );

  modport slave (
    input  ack, irq,
    output gnt, gnt_valid, gnt_id, irq_out, timeout
  );
endinterface

// File: rtl/multi_chan_gnt_arb.sv
// multi_chan_gnt_arb
// Round-robin grant arbiter for NCH channels sharing one resource. A single
// one-hot grant is issued at a time; the winner's irq vector is captured when
// the grant is issued. A grant held for MAX_HOLD cycles is revoked and a
// one-cycle timeout pulse is raised.
// Ports:
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : multi_chan_gnt_arb_if slave modport (ack/irq in, gnt/gnt_valid/
//           gnt_id/irq_out/timeout out, all outputs registered)
module multi_chan_gnt_arb #(
  parameter int NCH      = 4,
  parameter int IRQ_W    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multi_chan_gnt_arb_if.slave    bus
);
  localparam int IDW = $clog2(NCH);
  localparam int HW  = $clog2(MAX_HOLD);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST_CH   = IDW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_r, state_n;
  logic [IDW-1:0]   ptr_r, ptr_n;
  logic [HW-1:0]    hold_cnt_r, hold_n;
  logic [NCH-1:0]   gnt_r, gnt_n;
  logic             gnt_valid_r;
  logic [IDW-1:0]   gnt_id_r, gnt_id_n;
  logic [IRQ_W-1:0] irq_out_r, irq_out_n;
  logic             timeout_r, timeout_n;
  logic [IDW-1:0]   winner_s;
  logic [IRQ_W-1:0] irq_a_s [NCH];

  // First requesting channel found when scanning start, start+1, ... mod NCH.
  function automatic logic [IDW-1:0] rr_pick(input logic [NCH-1:0] req,
                                             input logic [IDW-1:0] start);
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx = IDW'((int'(start) + i) % NCH);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // Unflatten the irq bus so the winner's slice can be picked by index.
  for (genvar g = 0; g < NCH; g++) begin : g_irq
    assign irq_a_s[g] = bus.irq[g*IRQ_W +: IRQ_W];
  end

  assign winner_s = rr_pick(bus.ack, ptr_r);

  // Next-state and next-output logic of the arbitration FSM.
  always_comb begin
    state_n   = state_r;
    ptr_n     = ptr_r;
    hold_n    = hold_cnt_r;
    gnt_n     = gnt_r;
    gnt_id_n  = gnt_id_r;
    irq_out_n = irq_out_r;
    timeout_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (|bus.ack) begin
          state_n   = GRANT;
          gnt_n     = {{(NCH-1){1'b0}}, 1'b1} << winner_s;
          gnt_id_n  = winner_s;
          irq_out_n = irq_a_s[winner_s];
          hold_n    = '0;
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        // A voluntary release wins over the hold limit when both coincide.
        if (!bus.ack[gnt_id_r]) begin
          state_n = RELEASE;
          gnt_n   = '0;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_n   = RELEASE;
          gnt_n     = '0;
          timeout_n = 1'b1;
        end else begin
          hold_n = hold_cnt_r + HW'(1);
        end
      end
      RELEASE: begin
        // Channel just served gets lowest priority next round.
        state_n = IDLE;
        ptr_n   = (gnt_id_r == LAST_CH) ? '0 : gnt_id_r + IDW'(1);
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      hold_cnt_r  <= '0;
      gnt_r       <= '0;
      gnt_valid_r <= 1'b0;
      gnt_id_r    <= '0;
      irq_out_r   <= '0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      ptr_r       <= ptr_n;
      hold_cnt_r  <= hold_n;
      gnt_r       <= gnt_n;
      gnt_valid_r <= |gnt_n;
      gnt_id_r    <= gnt_id_n;
      irq_out_r   <= irq_out_n;
      timeout_r   <= timeout_n;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.gnt_id    = gnt_id_r;
  assign bus.irq_out   = irq_out_r;
  assign bus.timeout   = timeout_r;
endmodule

// File: tb/tb_multi_chan_gnt_arb.sv
// tb_multi_chan_gnt_arb
// Directed stimulus with a scoreboard: each expected grant (channel, captured
// irq, length, timeout) is queued before the acks are raised; a monitor on the
// falling edge pops an entry at each grant start and checks the grant through
// to its release. The driver drops a channel's ack after a per-grant hold
// length (0 = keep ack high).
`timescale 1ns/1ps
module tb_multi_chan_gnt_arb;
  localparam int NCH      = 4;
  localparam int IRQ_W    = 8;
  localparam int MAX_HOLD = 16;
  localparam int BUDGET   = 200;

  logic clk = 1'b0;
  logic rst_n;

  multi_chan_gnt_arb_if #(.NCH(NCH), .IRQ_W(IRQ_W)) bus ();

  multi_chan_gnt_arb #(.NCH(NCH), .IRQ_W(IRQ_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] irq;
    int         len;   // 0 = grant aborted by reset, length not checked
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   hold_q[$];
  int   checks;
  int   errors;
  logic mon_busy;
  int   run_len;
  int   cur_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int id, input logic [7:0] irq, input int len,
                      input logic to, input int hold);
    exp_t e;
    e.id = id; e.irq = irq; e.len = len; e.to = to;
    exp_q.push_back(e);
    hold_q.push_back(hold);
  endtask

  task automatic set_irq(input int ch, input logic [7:0] v);
    bus.irq[ch*IRQ_W +: IRQ_W] = v;
  endtask

  // One clock: advance past the edge, then play the agents' side.
  task automatic tick();
    int w;
    @(posedge clk);
    #1;
    w = -1;
    for (int i = 0; i < NCH; i++) if (bus.gnt[i]) w = i;
    if (w < 0) begin
      run_len = 0;
    end else begin
      run_len++;
      if (run_len == 1) begin
        cur_hold = (hold_q.size() > 0) ? hold_q.pop_front() : 0;
        // ch2 changes its irq right after being granted
        if (w == 2 && bus.irq[2*IRQ_W +: IRQ_W] == 8'hA5) set_irq(2, 8'h3C);
      end
      if (cur_hold != 0 && run_len == cur_hold) bus.ack[w] = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < BUDGET) begin
      tick();
      n++;
    end
    chk({name, "_complete"}, 32'(n < BUDGET), 32'd1);
  endtask

  task automatic wait_gnt(input int ch);
    int n;
    n = 0;
    while (!bus.gnt[ch] && n < BUDGET) begin
      tick();
      n++;
    end
    chk("wait_gnt", 32'(bus.gnt[ch]), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_gnt_valid"}, 32'(bus.gnt_valid), 32'd0);
    chk({tag, "_gnt_id"}, 32'(bus.gnt_id), 32'd0);
    chk({tag, "_irq_out"}, 32'(bus.irq_out), 32'd0);
    chk({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
  endtask

  // Stimulus
  initial begin
    checks = 0; errors = 0; run_len = 0; cur_hold = 0;
    rst_n = 1'b0;
    bus.ack = 4'hF;
    bus.irq = '0;
    set_irq(0, 8'h10); set_irq(1, 8'h21); set_irq(2, 8'hA5); set_irq(3, 8'h43);
    tick(); tick();
    chk_zero("reset");

    // Round robin 0,1,2,3 with 3-cycle grants, ch2 irq changes mid-grant
    push(0, 8'h10, 3, 1'b0, 3);
    push(1, 8'h21, 3, 1'b0, 3);
    push(2, 8'hA5, 3, 1'b0, 3);
    push(3, 8'h43, 3, 1'b0, 3);
    rst_n = 1'b1;
    tick();
    chk("first_grant_latency", 32'(bus.gnt), 32'h1);
    wait_idle("rr");
    push(0, 8'h10, 3, 1'b0, 3);
    bus.ack[0] = 1'b1;
    wait_idle("rr_ch0_again");

    // Timeout on ch1, then ch3, then ch1 released exactly at its 16th cycle
    push(1, 8'h21, 16, 1'b1, 0);
    push(3, 8'h43, 3, 1'b0, 3);
    push(1, 8'h21, 16, 1'b0, 16);
    bus.ack = 4'b1010;
    wait_idle("timeout");

    // Pointer wrap after ch3: ch0 beats ch1; acks raised during ch3's grant
    push(3, 8'h43, 3, 1'b0, 3);
    push(0, 8'h10, 3, 1'b0, 3);
    push(1, 8'h21, 3, 1'b0, 3);
    bus.ack[3] = 1'b1;
    wait_gnt(3);
    bus.ack[0] = 1'b1;
    bus.ack[1] = 1'b1;
    wait_idle("wrap");

    // Reset while ch2 is granted; afterwards ptr=0 so ch1 beats ch2
    push(2, 8'h3C, 0, 1'b0, 0);
    bus.ack[2] = 1'b1;
    wait_gnt(2);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk_zero("mid_grant_reset");
    push(1, 8'h21, 3, 1'b0, 3);
    push(2, 8'h3C, 3, 1'b0, 3);
    bus.ack[1] = 1'b1;
    rst_n = 1'b1;
    wait_idle("after_reset");

    chk("holds_consumed", 32'(hold_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: pops the expected grant at each grant start and follows it.
  initial begin : monitor
    exp_t       cur;
    int         len;
    int         gap;
    logic       have_prev;
    logic       prev_rst;
    logic [7:0] last_irq;
    int         last_id;
    mon_busy = 1'b0;
    len = 0; gap = 0; have_prev = 1'b0; prev_rst = 1'b0;
    last_irq = 8'h00; last_id = 0;
    cur.id = 0; cur.irq = 8'h00; cur.len = 0; cur.to = 1'b0;
    forever begin
      @(negedge clk);
      if (!prev_rst) begin
        mon_busy = 1'b0; have_prev = 1'b0;
        last_irq = 8'h00; last_id = 0; len = 0;
      end else begin
        chk("gnt_valid_is_or", 32'(bus.gnt_valid), 32'(|bus.gnt));
        chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
        if (bus.gnt_valid && !mon_busy) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_grant: got id %0d expected none", bus.gnt_id);
            cur.id = -1; cur.irq = 8'h00; cur.len = 0; cur.to = 1'b0;
          end else begin
            cur = exp_q.pop_front();
          end
          if (have_prev) chk("grant_gap_ge2", 32'(gap >= 2), 32'd1);
          chk("start_gnt_id", 32'(bus.gnt_id), cur.id);
          chk("start_gnt", 32'(bus.gnt), 32'd1 << cur.id);
          chk("start_irq_out", 32'(bus.irq_out), 32'(cur.irq));
          chk("start_timeout", 32'(bus.timeout), 32'd0);
          len = 1;
          mon_busy = 1'b1;
        end else if (bus.gnt_valid && mon_busy) begin
          len++;
          chk("hold_gnt_id", 32'(bus.gnt_id), cur.id);
          chk("hold_gnt", 32'(bus.gnt), 32'd1 << cur.id);
          chk("hold_irq_out", 32'(bus.irq_out), 32'(cur.irq));
          chk("hold_timeout", 32'(bus.timeout), 32'd0);
        end else if (!bus.gnt_valid && mon_busy) begin
          chk("end_timeout", 32'(bus.timeout), 32'(cur.to));
          if (cur.len != 0) chk("grant_length", len, cur.len);
          chk("end_irq_out", 32'(bus.irq_out), 32'(cur.irq));
          chk("end_gnt_id", 32'(bus.gnt_id), cur.id);
          mon_busy = 1'b0;
          have_prev = 1'b1;
          gap = 1;
          last_irq = cur.irq;
          last_id = cur.id;
        end else begin
          chk("idle_timeout", 32'(bus.timeout), 32'd0);
          chk("idle_irq_out_kept", 32'(bus.irq_out), 32'(last_irq));
          chk("idle_gnt_id_kept", 32'(bus.gnt_id), last_id);
          gap++;
        end
      end
      prev_rst = rst_n;
    end
  end
endmodule
